// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter sharing one L2 SRAM bank between NB_REQ TCDM requesters.
// The grant is issued in the request cycle; the response follows one cycle later.
module l2_bank_rr_arbiter #(
    parameter int NB_REQ     = 6,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_REQ-1:0]              req_i,
    input  logic [NB_REQ-1:0]              wen_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   add_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0] be_i,
    output logic [NB_REQ-1:0]              gnt_o,
    output logic [NB_REQ-1:0]              r_valid_o,
    output logic [DATA_WIDTH-1:0]          r_rdata_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        mem_be_o,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    input  logic                           mem_ready_i
);

    localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NB_REQ - 1);

    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic              rvalid_q, rvalid_d;
    logic [PTR_W-1:0]  win_s;
    logic              found_s;
    logic [NB_REQ-1:0] gnt_s;
    logic [NB_REQ-1:0] r_valid_s;

    // Candidate index for scan offset off starting at base, wrapping at NB_REQ.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        return PTR_W'((int'(base) + off) % NB_REQ);
    endfunction

    // Winner search: first asserted request at or above the pointer, with wrap.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        if (mem_ready_i) begin
            for (int o = 0; o < NB_REQ; o++) begin
                if (!found_s && req_i[wrap_idx(rr_q, o)]) begin
                    found_s = 1'b1;
                    win_s   = wrap_idx(rr_q, o);
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

    // Grant vector and memory-side mux; everything is zero when idle.
    always_comb begin
        gnt_s       = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (found_s) begin
            gnt_s[win_s] = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = ~wen_i[win_s];
            mem_addr_o   = add_i[win_s*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o  = wdata_i[win_s*DATA_WIDTH +: DATA_WIDTH];
            mem_be_o     = be_i[win_s*BE_W +: BE_W];
        end else begin
            gnt_s = '0;
        end
    end

    // Next-state: pointer moves past the winner, response tracks the grant.
    always_comb begin
        rr_d     = rr_q;
        idx_d    = idx_q;
        rvalid_d = found_s;
        if (found_s) begin
            idx_d = win_s;
            if (win_s == LAST_IDX) begin
                rr_d = '0;
            end else begin
                rr_d = win_s + PTR_W'(1);
            end
        end else begin
            rr_d  = rr_q;
            idx_d = idx_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            idx_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Response valid decoded from registered state only.
    always_comb begin
        r_valid_s = '0;
        if (rvalid_q) begin
            r_valid_s[idx_q] = 1'b1;
        end else begin
            r_valid_s = '0;
        end
    end

    assign gnt_o     = gnt_s;
    assign r_valid_o = r_valid_s;
    assign r_rdata_o = mem_rdata_i;

endmodule
